score_tx_reporter: RTL and testbench
====================================

SCORE_TX_REPORTER -- requirements
Module: score_tx_reporter

Interface
REQ-001 SHALL have parameter CLK_FREQ_HZ, default 65000000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 9600, UART bit rate.
REQ-003 SHALL have port clk, input, 1, single clock; all logic on the rising edge.
REQ-004 SHALL have port rst, input, 1, reset: asynchronous, active-high.
REQ-005 SHALL have port score, input, 16, unsigned binary game score.
REQ-006 SHALL have port send_req, input, 1, single-cycle request to transmit a score frame.
REQ-007 SHALL have port tx, output, 1, UART serial line: 8N1, idle high.
REQ-008 SHALL have port busy, output, 1, high from request acceptance until frame completion.
REQ-009 SHALL have port done, output, 1, one-cycle pulse when a frame finishes.

Function
REQ-010 SHALL use bit period DIV = round(CLK_FREQ_HZ/BAUD) cycles; 6771 at the defaults.
REQ-011 SHALL transmit a frame of 8 bytes, in order: 0x53 ('S'), five ASCII decimal digits of the captured score (most significant first, leading zeros kept), 0x0D, 0x0A.
REQ-012 SHALL send each byte as 1 start bit (0), 8 data bits LSB first, and 1 stop bit (1), each held exactly DIV cycles; no idle gap between bytes.
REQ-013 SHALL implement states IDLE, CONVERT, START, DATA, STOP, NEXT.
REQ-014 IDLE: send_req=1 sampled at edge k -> capture score; busy=1 after edge k; go to CONVERT.
REQ-015 CONVERT: SHALL run 16 cycles of iterative binary-to-BCD (shift-add-3) on edges k+1..k+16; tx falls (START) after edge k+17.
REQ-016 START/DATA/STOP: bit counter 0..7 in DATA; baud counter counts 0..DIV-1 and wraps; state advances on wrap.
REQ-017 NEXT: byte index 0..7; index<7 -> load next byte and go to START in the same cycle without an extra bit time; index=7 -> go to IDLE.
REQ-018 SHALL clear busy and pulse done for exactly one cycle on the edge that ends the stop bit of byte 7 (0x0A).
REQ-019 send_req while busy SHALL set a single pending flag; further requests while pending is set are dropped.
REQ-020 With pending set at frame end, the block SHALL return to IDLE for one cycle (busy=0, done=1), then accept the pending request, capture the score present at that cycle, and clear pending.
REQ-021 Changes to score after capture SHALL NOT alter the frame in progress.
REQ-022 Frame length SHALL be 80*DIV cycles from the falling edge of the first start bit to the end of the last stop bit.

Reset
REQ-023 On rst=1, asynchronously: tx=1, busy=0, done=0, pending=0, state=IDLE, all counters and byte index = 0.
REQ-024 Reset mid-frame SHALL abort immediately; tx returns high with no done pulse, and no partial byte is resumed after reset release.
REQ-025 First request accepted SHALL be a send_req sampled on or after the first edge after rst deasserts.

Structure
REQ-026 Shared package snake_pkg SHALL hold CLK_FREQ_HZ, BAUD, derived DIV, ASCII constants (0x53, 0x30, 0x0D, 0x0A), and the state encoding.
REQ-027 Sub-module bin2bcd_seq SHALL hold the 16-cycle iterative converter (start/ready handshake, 20-bit BCD output); all serialisation stays in score_tx_reporter.
REQ-028 tx SHALL be driven directly from a flip-flop, with no combinational path to the pin.

Verification
REQ-029 score=1234, send_req pulse -> decoded bytes 53 30 31 32 33 34 0D 0A; each bit 6771 cycles; tx falls 18 cycles after request; one done pulse.
REQ-030 score=65535 -> digits 36 35 35 33 35; score=0 -> digits 30 30 30 30 30.
REQ-031 Second send_req during byte 3 with score changed to 7 -> first frame unchanged; second frame follows with digits 30 30 30 30 37; no third frame.
REQ-032 Three send_req pulses during one frame -> exactly two frames total.
REQ-033 rst asserted during DATA of byte 2 -> tx=1 and busy=0 the same cycle; no done; a new send_req after release produces a complete, correct frame.
REQ-034 Idle with send_req=0 for 1e6 cycles -> tx stays 1, busy 0, done never pulses.

Source files
------------

// File: rtl/snake_pkg.sv
// ---------------------------------------------------------------------------
// snake_pkg
// Shared constants and types for the score UART reporter.
//   CLK_FREQ_HZ / BAUD : default system clock and UART bit rate
//   DIV                : cycles per UART bit, rounded to nearest
//   ASCII_*            : frame characters ('S', '0', CR, LF)
//   state_t            : serialiser state encoding
//   frame_byte()       : byte N of the 8-byte score frame
// ---------------------------------------------------------------------------
package snake_pkg;

   localparam int CLK_FREQ_HZ = 65000000;
   localparam int BAUD        = 9600;

   // Round-to-nearest integer division for the bit period.
   function automatic int calc_div(input int clk_hz, input int baud_rate);
      return (clk_hz + baud_rate / 2) / baud_rate;
   endfunction

   localparam int DIV = calc_div(CLK_FREQ_HZ, BAUD);   // 6771 at defaults

   localparam int SCORE_W     = 16;
   localparam int BCD_DIGITS  = 5;
   localparam int BCD_W       = 4 * BCD_DIGITS;
   localparam int FRAME_BYTES = 8;

   localparam logic [7:0] ASCII_S  = 8'h53;
   localparam logic [7:0] ASCII_0  = 8'h30;
   localparam logic [7:0] ASCII_CR = 8'h0D;
   localparam logic [7:0] ASCII_LF = 8'h0A;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_CONVERT = 3'd1,
      ST_START   = 3'd2,
      ST_DATA    = 3'd3,
      ST_STOP    = 3'd4,
      ST_NEXT    = 3'd5
   } state_t;

   // Frame layout: 'S', five digits (most significant first), CR, LF.
   function automatic logic [7:0] frame_byte(input logic [2:0] idx,
                                             input logic [BCD_W-1:0] bcd);
      case (idx)
         3'd0:    frame_byte = ASCII_S;
         3'd1:    frame_byte = ASCII_0 | {4'd0, bcd[19:16]};
         3'd2:    frame_byte = ASCII_0 | {4'd0, bcd[15:12]};
         3'd3:    frame_byte = ASCII_0 | {4'd0, bcd[11:8]};
         3'd4:    frame_byte = ASCII_0 | {4'd0, bcd[7:4]};
         3'd5:    frame_byte = ASCII_0 | {4'd0, bcd[3:0]};
         3'd6:    frame_byte = ASCII_CR;
         default: frame_byte = ASCII_LF;
      endcase
   endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// ---------------------------------------------------------------------------
// bin2bcd_seq
// Iterative 16-bit binary to 5-digit BCD converter (shift-add-3), one bit
// per clock. A start pulse captures the input; sixteen following edges do
// the conversion; the result is held until the next start.
//   i_clk   : clock
//   i_rst   : asynchronous active-high reset
//   i_start : capture i_bin and begin converting
//   i_bin   : binary value to convert
//   o_ready : high when idle (result valid after a conversion)
//   o_bcd   : five BCD digits, most significant digit in [19:16]
// ---------------------------------------------------------------------------
module bin2bcd_seq
   import snake_pkg::*;
(
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_start,
   input  logic [SCORE_W-1:0] i_bin,
   output logic               o_ready,
   output logic [BCD_W-1:0]   o_bcd
);

   logic [SCORE_W-1:0] r_bin;
   logic [BCD_W-1:0]   r_bcd;
   logic [3:0]         r_cnt;
   logic               r_busy;

   // Add-3 correction for the lower four digits. The top digit of a 16-bit
   // value never reaches 5 before a shift (final value is at most 6), so it
   // is shifted without correction and nothing falls off the top.
   logic [BCD_W-5:0]   w_adj;

   genvar gi;
   generate
      for (gi = 0; gi < BCD_DIGITS - 1; gi++) begin : g_adj
         assign w_adj[gi*4 +: 4] = (r_bcd[gi*4 +: 4] >= 4'd5) ?
                                   (r_bcd[gi*4 +: 4] + 4'd3) :
                                    r_bcd[gi*4 +: 4];
      end
   endgenerate

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_bin  <= '0;
         r_bcd  <= '0;
         r_cnt  <= '0;
         r_busy <= 1'b0;
      end else if (i_start) begin
         r_bin  <= i_bin;
         r_bcd  <= '0;
         r_cnt  <= '0;
         r_busy <= 1'b1;
      end else if (r_busy) begin
         r_bin  <= {r_bin[SCORE_W-2:0], 1'b0};
         r_bcd  <= {r_bcd[BCD_W-2:BCD_W-4], w_adj, r_bin[SCORE_W-1]};
         r_cnt  <= r_cnt + 4'd1;
         if (r_cnt == 4'd15) begin
            r_busy <= 1'b0;
         end
      end
   end

   assign o_ready = ~r_busy;
   assign o_bcd   = r_bcd;

endmodule

// File: rtl/score_tx_reporter.sv
// ---------------------------------------------------------------------------
// score_tx_reporter
// Sends a captured 16-bit score over a UART (8N1) as the 8-byte frame
// "S" d4 d3 d2 d1 d0 CR LF. One extra request arriving during a frame is
// remembered and served right after the current frame.
//   clk      : clock, rising edge
//   rst      : asynchronous active-high reset
//   score    : unsigned score, captured when a request is accepted
//   send_req : single-cycle transmit request
//   tx       : serial output, idle high, driven from a flip-flop
//   busy     : high from request acceptance until frame completion
//   done     : one-cycle pulse at frame completion
// ---------------------------------------------------------------------------
module score_tx_reporter #(
   parameter int CLK_FREQ_HZ = snake_pkg::CLK_FREQ_HZ,
   parameter int BAUD        = snake_pkg::BAUD
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] score,
   input  logic        send_req,
   output logic        tx,
   output logic        busy,
   output logic        done
);

   import snake_pkg::*;

   // DIV must be at least 2: the NEXT state consumes the first cycle of
   // each following start bit.
   localparam int                DIV       = calc_div(CLK_FREQ_HZ, BAUD);
   localparam int                BAUD_W    = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(DIV - 1);

   state_t              r_state;
   state_t              w_state_next;
   logic [BAUD_W-1:0]   r_baud;
   logic [BAUD_W-1:0]   w_baud_next;
   logic [2:0]          r_bit;
   logic [2:0]          w_bit_next;
   logic [2:0]          r_idx;
   logic [2:0]          w_idx_next;
   logic                r_tx;
   logic                w_tx_next;
   logic                r_busy;
   logic                w_busy_next;
   logic                r_done;
   logic                w_done_next;
   logic                r_pending;
   logic                w_pending_next;

   logic                w_conv_start;
   logic                w_bcd_ready;
   logic [BCD_W-1:0]    w_bcd;
   logic [7:0]          w_cur_byte;
   logic [2:0]          w_bit_inc;
   logic                w_baud_wrap;
   logic                w_accept;

   // The converter holds the captured score and its digits for the whole
   // frame, so later score changes cannot disturb a frame in progress.
   bin2bcd_seq u_bcd (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_start (w_conv_start),
      .i_bin   (score),
      .o_ready (w_bcd_ready),
      .o_bcd   (w_bcd)
   );

   assign w_cur_byte  = frame_byte(r_idx, w_bcd);
   assign w_bit_inc   = r_bit + 3'd1;
   assign w_baud_wrap = (r_baud == BAUD_LAST);
   assign w_accept    = send_req | r_pending;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_baud    <= '0;
         r_bit     <= '0;
         r_idx     <= '0;
         r_tx      <= 1'b1;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_pending <= 1'b0;
      end else begin
         r_baud    <= w_baud_next;
         r_bit     <= w_bit_next;
         r_idx     <= w_idx_next;
         r_tx      <= w_tx_next;
         r_busy    <= w_busy_next;
         r_done    <= w_done_next;
         r_pending <= w_pending_next;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE:    if (w_accept)    w_state_next = ST_CONVERT;
         ST_CONVERT: if (w_bcd_ready) w_state_next = ST_START;
         ST_START:   if (w_baud_wrap) w_state_next = ST_DATA;
         ST_DATA:    if (w_baud_wrap && (r_bit == 3'd7)) w_state_next = ST_STOP;
         ST_STOP: begin
            if (w_baud_wrap) begin
               w_state_next = (r_idx == 3'd7) ? ST_IDLE : ST_NEXT;
            end
         end
         ST_NEXT:    w_state_next = ST_START;
         default:    w_state_next = ST_IDLE;
      endcase
   end

   // Output / datapath logic
   always_comb begin
      w_baud_next    = r_baud;
      w_bit_next     = r_bit;
      w_idx_next     = r_idx;
      w_tx_next      = r_tx;
      w_busy_next    = r_busy;
      w_done_next    = 1'b0;
      w_pending_next = r_pending;
      w_conv_start   = 1'b0;

      // A single request can be queued while a frame is running.
      if (r_busy && send_req) begin
         w_pending_next = 1'b1;
      end

      case (r_state)
         ST_IDLE: begin
            w_tx_next = 1'b1;
            if (w_accept) begin
               w_conv_start   = 1'b1;
               w_busy_next    = 1'b1;
               w_pending_next = 1'b0;
               w_idx_next     = '0;
               w_bit_next     = '0;
               w_baud_next    = '0;
            end
         end
         ST_CONVERT: begin
            if (w_bcd_ready) begin
               w_tx_next   = 1'b0;
               w_baud_next = '0;
            end
         end
         ST_START: begin
            if (w_baud_wrap) begin
               w_baud_next = '0;
               w_bit_next  = '0;
               w_tx_next   = w_cur_byte[0];
            end else begin
               w_baud_next = r_baud + 1'b1;
            end
         end
         ST_DATA: begin
            if (w_baud_wrap) begin
               w_baud_next = '0;
               if (r_bit == 3'd7) begin
                  w_tx_next = 1'b1;
               end else begin
                  w_bit_next = w_bit_inc;
                  w_tx_next  = w_cur_byte[w_bit_inc];
               end
            end else begin
               w_baud_next = r_baud + 1'b1;
            end
         end
         ST_STOP: begin
            if (w_baud_wrap) begin
               w_baud_next = '0;
               if (r_idx == 3'd7) begin
                  w_tx_next   = 1'b1;
                  w_busy_next = 1'b0;
                  w_done_next = 1'b1;
               end else begin
                  // Next start bit begins right here; NEXT is its first cycle.
                  w_tx_next = 1'b0;
               end
            end else begin
               w_baud_next = r_baud + 1'b1;
            end
         end
         ST_NEXT: begin
            w_idx_next  = r_idx + 3'd1;
            w_baud_next = r_baud + 1'b1;
         end
         default: begin
            w_tx_next = 1'b1;
         end
      endcase
   end

   assign tx   = r_tx;
   assign busy = r_busy;
   assign done = r_done;

endmodule

// File: tb/tb_score_tx_reporter.sv
// ---------------------------------------------------------------------------
// tb_score_tx_reporter
// Directed bench for score_tx_reporter with a shortened bit period. Expected
// frame bytes are queued when a request is issued; a UART receiver process
// decodes tx and pops/compares each byte.
// ---------------------------------------------------------------------------
module tb_score_tx_reporter;

   localparam int TB_CLK_HZ = 160000;
   localparam int TB_BAUD   = 10000;
   localparam int DIV       = 16;     // round(160000 / 10000)

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] score;
   logic        send_req;
   logic        tx;
   logic        busy;
   logic        done;

   int          n_tests = 0;
   int          n_fail  = 0;
   int          cyc     = 0;
   int          done_cnt = 0;
   logic [7:0]  sb_q[$];

   score_tx_reporter #(
      .CLK_FREQ_HZ (TB_CLK_HZ),
      .BAUD        (TB_BAUD)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .score    (score),
      .send_req (send_req),
      .tx       (tx),
      .busy     (busy),
      .done     (done)
   );

   initial forever #5 clk = ~clk;
   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push_frame(input int s);
      sb_q.push_back(8'h53);
      sb_q.push_back(8'(8'h30 + (s / 10000) % 10));
      sb_q.push_back(8'(8'h30 + (s / 1000) % 10));
      sb_q.push_back(8'(8'h30 + (s / 100) % 10));
      sb_q.push_back(8'(8'h30 + (s / 10) % 10));
      sb_q.push_back(8'(8'h30 + s % 10));
      sb_q.push_back(8'h0D);
      sb_q.push_back(8'h0A);
   endtask

   task automatic pulse_req(input logic [15:0] s);
      @(negedge clk);
      score    = s;
      send_req = 1'b1;
      @(negedge clk);
      send_req = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int budget);
      int n;
      n = 0;
      while (done !== 1'b1 && n < budget) begin
         @(negedge clk);
         n++;
      end
      check(tag, {31'd0, done}, 32'd1);
   endtask

   // UART receiver / scoreboard consumer
   initial begin
      int         mon_cnt;
      int         frame_bytes;
      int         frame_fall;
      int         last_fall;
      logic       mon_active;
      logic [7:0] mon_shift;
      logic [31:0] exp_byte;
      mon_active  = 1'b0;
      mon_cnt     = 0;
      frame_bytes = 0;
      frame_fall  = 0;
      last_fall   = 0;
      mon_shift   = '0;
      forever begin
         @(negedge clk);
         if (rst === 1'b1) begin
            mon_active  = 1'b0;
            frame_bytes = 0;
         end else begin
            if (done === 1'b1) begin
               done_cnt++;
               check("frame_byte_count", frame_bytes, 8);
               check("frame_length", cyc - frame_fall, 80 * DIV);
               $display("[TB] frame %0d complete at cycle %0d", done_cnt, cyc);
               frame_bytes = 0;
            end
            if (!mon_active) begin
               if (tx === 1'b0) begin
                  mon_active = 1'b1;
                  mon_cnt    = 0;
                  if (frame_bytes == 0) frame_fall = cyc;
                  else check("byte_gap", cyc - last_fall, 10 * DIV);
                  last_fall = cyc;
               end
            end else begin
               mon_cnt++;
               if (mon_cnt == DIV / 2) begin
                  check("start_bit", {31'd0, tx}, 32'd0);
               end else if (mon_cnt == 9 * DIV + DIV / 2) begin
                  check("stop_bit", {31'd0, tx}, 32'd1);
                  exp_byte = 'x;
                  if (sb_q.size() > 0) exp_byte = {24'd0, sb_q.pop_front()};
                  check("rx_byte", {24'd0, mon_shift}, exp_byte);
                  frame_bytes++;
                  mon_active = 1'b0;
               end else if (mon_cnt > DIV / 2 && ((mon_cnt - DIV / 2) % DIV) == 0) begin
                  mon_shift = {tx, mon_shift[7:1]};
               end
            end
         end
      end
   end

   // Directed stimulus
   initial begin
      int lat;
      int bad;
      int done_before;
      logic busy_first;

      rst      = 1'b1;
      send_req = 1'b0;
      score    = '0;
      repeat (3) @(negedge clk);
      check("reset_tx", {31'd0, tx}, 32'd1);
      check("reset_busy", {31'd0, busy}, 32'd0);
      check("reset_done", {31'd0, done}, 32'd0);
      rst = 1'b0;
      repeat (3) @(negedge clk);

      // Frame 1: score 1234, start latency and done pulse width
      @(negedge clk);
      score    = 16'd1234;
      send_req = 1'b1;
      push_frame(1234);
      lat = 0;
      busy_first = 1'b0;
      do begin
         @(negedge clk);
         send_req = 1'b0;
         lat++;
         if (lat == 1) busy_first = busy;
      end while (tx !== 1'b0 && lat < 100);
      check("busy_after_accept", {31'd0, busy_first}, 32'd1);
      check("start_latency", lat, 18);
      wait_done("done_1234", 2000);
      check("busy_at_done", {31'd0, busy}, 32'd0);
      @(negedge clk);
      check("done_one_cycle", {31'd0, done}, 32'd0);

      // Frame 2: max score; score changed during conversion must not matter
      pulse_req(16'd65535);
      push_frame(65535);
      repeat (3) @(negedge clk);
      score = 16'd1;
      wait_done("done_65535", 2000);
      repeat (5) @(negedge clk);

      // Frame 3: zero
      pulse_req(16'd0);
      push_frame(0);
      wait_done("done_0", 2000);
      repeat (5) @(negedge clk);

      // Pending request issued during byte 3 with score changed to 7
      pulse_req(16'd4321);
      push_frame(4321);
      repeat (17 + 35 * DIV) @(negedge clk);
      pulse_req(16'd7);
      push_frame(7);
      wait_done("done_pend_first", 2000);
      check("pend_idle_busy", {31'd0, busy}, 32'd0);
      @(negedge clk);
      check("pend_accept_busy", {31'd0, busy}, 32'd1);
      check("pend_done_low", {31'd0, done}, 32'd0);
      wait_done("done_pend_second", 2000);
      done_before = done_cnt;
      repeat (300) @(negedge clk);
      check("no_third_frame", done_cnt, done_before);
      check("idle_after_pend", {31'd0, busy}, 32'd0);

      // Three extra requests during one frame -> exactly two frames
      pulse_req(16'd500);
      push_frame(500);
      repeat (100) @(negedge clk);
      pulse_req(16'd11);
      repeat (50) @(negedge clk);
      pulse_req(16'd22);
      repeat (50) @(negedge clk);
      pulse_req(16'd33);
      push_frame(33);
      wait_done("done_multi_first", 2000);
      @(negedge clk);
      wait_done("done_multi_second", 2000);
      done_before = done_cnt;
      repeat (300) @(negedge clk);
      check("multi_two_frames", done_cnt, done_before);

      // Reset during DATA of byte 2
      pulse_req(16'd9876);
      push_frame(9876);
      repeat (17 + 22 * DIV + DIV / 2) @(negedge clk);
      check("tx_before_reset", {31'd0, tx}, 32'd0);
      done_before = done_cnt;
      #2 rst = 1'b1;
      #1;
      check("abort_tx", {31'd0, tx}, 32'd1);
      check("abort_busy", {31'd0, busy}, 32'd0);
      sb_q.delete();
      repeat (3) @(negedge clk);
      rst = 1'b0;
      bad = 0;
      repeat (200) begin
         @(negedge clk);
         if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
      end
      check("no_resume_after_reset", bad, 0);
      check("no_done_on_abort", done_cnt, done_before);
      pulse_req(16'd42);
      push_frame(42);
      wait_done("done_after_reset", 2000);
      repeat (5) @(negedge clk);

      // Long idle: line stays quiet
      bad = 0;
      repeat (2000) begin
         @(negedge clk);
         if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
      end
      check("idle_quiet", bad, 0);

      check("sb_empty", sb_q.size(), 0);
      check("done_total", done_cnt, 8);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
